// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle core's unified memory port.
// Serves fetch/load/store requests from a word RAM after a programmable wait.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_be,
    output logic        o_ready,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [33:0] LIMIT_BYTES = 34'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic          mem_wr;
    logic [31:0]   in_off;
    logic          in_err;
    logic [31:0]   lat_off;
    logic [AW-1:0] idx;

    assign in_off  = i_addr - BASE_ADDR;
    assign in_err  = ({2'b00, in_off} >= LIMIT_BYTES) || (i_we && (i_be == 4'h0));
    assign lat_off = addr_q - BASE_ADDR;
    assign idx     = lat_off[AW+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        mem_wr  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_req) begin
                    we_d    = i_we;
                    addr_d  = i_addr;
                    wdata_d = i_wdata;
                    be_d    = i_be;
                    err_d   = in_err;
                    // WAIT is entered with the full count so the array access lands on the
                    // (WAIT_CYCLES+1)th edge, giving 2+WAIT_CYCLES clocks request-to-ready.
                    if (in_err) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    if (we_q) begin
                        mem_wr = 1'b1;
                    end else begin
                        rdata_d = mem_q[idx];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Array is not reset; a write only commits from WAIT, so reset discards it.
    always_ff @(posedge i_clk) begin
        if (mem_wr) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (be_q[k]) begin
                    mem_q[idx][8*k +: 8] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

    assign o_ready = (state_q == ST_RESP);
    assign o_err   = (state_q == ST_RESP) && err_q;
    assign o_rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: two builds (WAIT_CYCLES=2/BASE 0 and
// WAIT_CYCLES=0/BASE 0x100) checked against a word-array reference model.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, we;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [3:0]  be [2];
    logic        ready0, ready1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [1:0]  ready_a, err_a;
    logic [31:0] rdata_a [2];

    int unsigned depth [2];
    int unsigned wcyc [2];
    bit   [31:0] base [2];
    bit   [31:0] mdl [2][1024];
    bit   [31:0] last_rd [2];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    assign ready_a    = {ready1, ready0};
    assign err_a      = {err1, err0};
    assign rdata_a[0] = rdata0;
    assign rdata_a[1] = rdata1;

    mem_responder #(
        .DEPTH_WORDS(1024),
        .WAIT_CYCLES(2),
        .BASE_ADDR(32'h0000_0000)
    ) dut0 (
        .i_clk(clk), .i_rstn(rst_n), .i_req(req[0]), .i_we(we[0]),
        .i_addr(addr[0]), .i_wdata(wdata[0]), .i_be(be[0]),
        .o_ready(ready0), .o_rdata(rdata0), .o_err(err0)
    );

    mem_responder #(
        .DEPTH_WORDS(16),
        .WAIT_CYCLES(0),
        .BASE_ADDR(32'h0000_0100)
    ) dut1 (
        .i_clk(clk), .i_rstn(rst_n), .i_req(req[1]), .i_we(we[1]),
        .i_addr(addr[1]), .i_wdata(wdata[1]), .i_be(be[1]),
        .o_ready(ready1), .o_rdata(rdata1), .o_err(err1)
    );

    // One request on DUT d, issued at a negedge while the DUT is idle.
    task automatic txn(input int d, input bit w, input bit [31:0] a, input bit [31:0] wd,
                       input bit [3:0] b, input bit scramble, input string tag);
        bit [31:0] off, mask;
        bit        exp_err, got, stray;
        int        exp_lat, lat, idx;
        off     = a - base[d];
        exp_err = (64'(off) >= 64'(4 * depth[d])) || (w && b == 4'h0);
        exp_lat = exp_err ? 1 : 2 + int'(wcyc[d]);
        idx     = int'(off >> 2);
        if (!exp_err) begin
            if (w) begin
                for (int k = 0; k < 4; k++) mask[8*k +: 8] = {8{b[k]}};
                mdl[d][idx] = (mdl[d][idx] & ~mask) | (wd & mask);
            end else begin
                last_rd[d] = mdl[d][idx];
            end
        end
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
        got = 1'b0; lat = 0; stray = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            if (scramble && c == 1) begin
                req[d] = 1'b0; we[d] = ~w; addr[d] = ~a; wdata[d] = ~wd; be[d] = ~b;
            end
            if (ready_a[d]) begin
                got = 1'b1;
                lat = c;
            end else if (err_a[d]) begin
                stray = 1'b1;
            end
        end
        req[d] = 1'b0;
        checks++;
        if (!got) $display("FAIL %s timeout: o_ready never seen within 40 cycles", tag);
        else passes++;
        if (got) begin
            checks++;
            if (lat !== exp_lat) $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
            else passes++;
            checks++;
            if (err_a[d] !== exp_err) $display("FAIL %s o_err: got %0b want %0b", tag, err_a[d], exp_err);
            else passes++;
            checks++;
            if (rdata_a[d] !== last_rd[d]) $display("FAIL %s o_rdata: got %h want %h", tag, rdata_a[d], last_rd[d]);
            else passes++;
        end
        checks++;
        if (stray) $display("FAIL %s o_err high without o_ready: got 1 want 0", tag);
        else passes++;
        @(negedge clk);
        checks++;
        if (ready_a[d] !== 1'b0) $display("FAIL %s ready pulse width: o_ready got %b want 0", tag, ready_a[d]);
        else passes++;
    endtask

    task automatic test_reset;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ready_a[d] !== 1'b0 || err_a[d] !== 1'b0 || rdata_a[d] !== 32'h0)
                $display("FAIL reset_state dut%0d: ready=%b err=%b rdata=%h want 0/0/0",
                         d, ready_a[d], err_a[d], rdata_a[d]);
            else passes++;
        end
    endtask

    task automatic test_full_word;
        txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, "full_wr");
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, "full_rd");
        checks++;
        if (rdata_a[0] !== 32'hDEAD_BEEF) $display("FAIL full_rd_const: got %h want deadbeef", rdata_a[0]);
        else passes++;
    endtask

    task automatic test_byte_lanes;
        txn(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 1'b0, "lane_init");
        txn(0, 1'b1, 32'h22, 32'hAABB_CCDD, 4'b0101, 1'b0, "lane_wr");
        txn(0, 1'b0, 32'h23, 32'h0, 4'h0, 1'b0, "lane_rd");
        checks++;
        if (rdata_a[0] !== 32'h11BB_33DD) $display("FAIL lane_rd_const: got %h want 11bb33dd", rdata_a[0]);
        else passes++;
    endtask

    task automatic test_errors;
        txn(0, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, "err_range_rd");
        txn(0, 1'b1, 32'h10, 32'h0BAD_0BAD, 4'h0, 1'b0, "err_be0_wr");
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, "err_be0_chk");
        txn(0, 1'b0, 32'hFFC, 32'h0, 4'h0, 1'b0, "last_word_rd");
        txn(1, 1'b1, 32'h13C, 32'h7777_0001, 4'hF, 1'b0, "b1_last_wr");
        txn(1, 1'b0, 32'h13C, 32'h0, 4'h0, 1'b0, "b1_last_rd");
        txn(1, 1'b0, 32'h140, 32'h0, 4'h0, 1'b0, "b1_above");
        txn(1, 1'b0, 32'hFC, 32'h0, 4'h0, 1'b0, "b1_below");
        txn(1, 1'b1, 32'h0, 32'h1234_5678, 4'hF, 1'b0, "b1_wrap_wr");
    endtask

    task automatic test_input_hold;
        txn(0, 1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, 1'b1, "hold_wr");
        txn(0, 1'b0, 32'h30, 32'h0, 4'h0, 1'b1, "hold_rd");
        txn(1, 1'b1, 32'h104, 32'h0F0F_1234, 4'hC, 1'b1, "b1_hold_wr");
        txn(1, 1'b0, 32'h104, 32'h0, 4'h0, 1'b0, "b1_hold_rd");
    endtask

    // i_req held across RESP: the next IDLE cycle starts a second access.
    task automatic test_back_to_back(input int d);
        int first, second;
        first = 0; second = 0;
        last_rd[d] = mdl[d][0];
        req[d] = 1'b1; we[d] = 1'b0; addr[d] = base[d]; wdata[d] = '0; be[d] = '0;
        for (int c = 1; c <= 60 && second == 0; c++) begin
            @(negedge clk);
            if (ready_a[d]) begin
                if (first == 0) first = c;
                else second = c;
            end
        end
        req[d] = 1'b0;
        checks++;
        if (first != 2 + int'(wcyc[d]))
            $display("FAIL b2b_first dut%0d: latency got %0d want %0d", d, first, 2 + wcyc[d]);
        else passes++;
        checks++;
        if (second - first != 3 + int'(wcyc[d]))
            $display("FAIL b2b_spacing dut%0d: got %0d want %0d", d, second - first, 3 + wcyc[d]);
        else passes++;
        checks++;
        if (rdata_a[d] !== last_rd[d]) $display("FAIL b2b_rdata dut%0d: got %h want %h", d, rdata_a[d], last_rd[d]);
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        txn(0, 1'b1, 32'h14, 32'h5555_AAAA, 4'hF, 1'b0, "rst_pre_wr");
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h14; wdata[0] = 32'h1234_5678; be[0] = 4'hF;
        @(negedge clk);
        req[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ready_a[0] !== 1'b0 || err_a[0] !== 1'b0 || rdata_a[0] !== 32'h0)
            $display("FAIL rst_mid: ready=%b err=%b rdata=%h want 0/0/0", ready_a[0], err_a[0], rdata_a[0]);
        else passes++;
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn(0, 1'b0, 32'h14, 32'h0, 4'h0, 1'b0, "rst_readback");
    endtask

    task automatic test_random;
        bit [31:0] a;
        int        d, w_idx;
        for (int i = 0; i < 64; i++) txn(0, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, "fill0");
        txn(0, 1'b1, 32'hFFC, $urandom, 4'hF, 1'b0, "fill0_top");
        for (int i = 0; i < 16; i++) txn(1, 1'b1, 32'h100 + 32'(i * 4), $urandom, 4'hF, 1'b0, "fill1");
        for (int i = 0; i < 80; i++) begin
            d = i % 2;
            if (d == 0) begin
                w_idx = $urandom_range(0, 64);
                if (w_idx == 64) w_idx = 1023;
            end else begin
                w_idx = $urandom_range(0, 15);
            end
            a = base[d] + 32'(w_idx * 4) + 32'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0: a = base[d] + 32'(4 * depth[d]) + 32'($urandom_range(0, 255));
                1: a = base[d] - 32'($urandom_range(1, 64));
                default: ;
            endcase
            txn(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        depth[0] = 1024; wcyc[0] = 2; base[0] = 32'h0;
        depth[1] = 16;   wcyc[1] = 0; base[1] = 32'h100;
        last_rd[0] = '0; last_rd[1] = '0;
        rst_n = 1'b0;
        req = '0; we = '0;
        for (int d = 0; d < 2; d++) begin
            addr[d] = '0; wdata[d] = '0; be[d] = '0;
        end
        repeat (2) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_full_word;
        test_byte_lanes;
        test_errors;
        test_input_hold;
        test_back_to_back(1);
        test_back_to_back(0);
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
